// File: rtl/fifobram_dualmode.sv
// Operand buffer combining a random-access BRAM and a streaming FIFO behind one port set,
// with per-access mode select, pipelined reads (latency 1 or 2) and sticky error flags.
module fifobram_dualmode #(
  parameter int WIDTH             = 32,
  parameter int LOG2_DEPTH        = 5,
  parameter int READ_LATENCY      = 1,
  parameter int ALMOSTFULL_MARGIN = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  we_i,
  input  logic [LOG2_DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [1:0]            wfifobram_i,
  input  logic                  re_i,
  input  logic [LOG2_DEPTH-1:0] raddr_i,
  input  logic [1:0]            rfifobram_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  almostfull_o,
  output logic                  empty_o,
  output logic [LOG2_DEPTH-1:0] count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] FULL_CNT = LOG2_DEPTH'(DEPTH - 1);

  logic [WIDTH-1:0]      bram_q [DEPTH];
  logic [WIDTH-1:0]      fifo_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic                  empty_q, empty_d, almostfull_q, almostfull_d;
  logic                  overflow_q, underflow_q;
  logic                  bram_we, push_req, push_ok, pop_req, pop_ok, bram_re, rd_ok, full;
  logic                  vld1_q;
  logic [WIDTH-1:0]      dat1_q;

  always_comb begin
    bram_we  = we_i & wfifobram_i[0];
    push_req = we_i & wfifobram_i[1];
    full     = (count_q == FULL_CNT);
    push_ok  = push_req & ~full;
    pop_req  = re_i & (rfifobram_i == 2'b10);
    pop_ok   = pop_req & ~empty_q;
    // rfifobram 01 and 11 both address the BRAM
    bram_re  = re_i & rfifobram_i[0];
    rd_ok    = bram_re | pop_ok;
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d      = (count_d == '0);
    almostfull_d = (int'(FULL_CNT) - int'(count_d)) <= ALMOSTFULL_MARGIN;
  end

  // Storage arrays are never cleared; only their bookkeeping resets.
  always_ff @(posedge clk_i) begin
    if (bram_we) bram_q[waddr_i]  <= wdata_i;
    if (push_ok) fifo_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      almostfull_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      empty_q      <= empty_d;
      almostfull_q <= almostfull_d;
      if (push_req & full)   overflow_q  <= 1'b1;
      if (pop_req & empty_q) underflow_q <= 1'b1;
    end
  end

  // First read stage: registered array read gives old data on same-address write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld1_q <= 1'b0;
      dat1_q <= '0;
    end else begin
      vld1_q <= rd_ok;
      if (rd_ok) dat1_q <= bram_re ? bram_q[raddr_i] : fifo_q[rd_ptr_q];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             vld2_q;
      logic [WIDTH-1:0] dat2_q;
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          vld2_q <= 1'b0;
          dat2_q <= '0;
        end else begin
          vld2_q <= vld1_q;
          if (vld1_q) dat2_q <= dat1_q;
        end
      end
      assign rvalid_o = vld2_q;
      assign rdata_o  = dat2_q;
    end else begin : g_lat1
      assign rvalid_o = vld1_q;
      assign rdata_o  = dat1_q;
    end
  endgenerate

  assign count_o      = count_q;
  assign empty_o      = empty_q;
  assign almostfull_o = almostfull_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;
endmodule

// File: tb/tb_fifobram_dualmode.sv
// Directed bench: instance A at read latency 1 (BRAM/FIFO/boundary/reset), instance B at
// read latency 2 (back-to-back reads, read-during-write, reset with reads in flight).
module tb_fifobram_dualmode;
  logic        clk = 1'b0;
  logic        reset;
  logic        we, re;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [1:0]  wfb, rfb;
  logic [31:0] rdata;
  logic        rvalid, almostfull, empty, overflow, underflow;
  logic [4:0]  count;

  logic        b_we, b_re;
  logic [4:0]  b_waddr, b_raddr;
  logic [31:0] b_wdata;
  logic [1:0]  b_wfb, b_rfb;
  logic [31:0] b_rdata;
  logic        b_rvalid, b_almostfull, b_empty, b_overflow, b_underflow;
  logic [4:0]  b_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifobram_dualmode #(.WIDTH(32), .LOG2_DEPTH(5), .READ_LATENCY(1), .ALMOSTFULL_MARGIN(4)) u_a (
    .clk_i(clk), .reset_i(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wfifobram_i(wfb), .re_i(re), .raddr_i(raddr), .rfifobram_i(rfb),
    .rdata_o(rdata), .rvalid_o(rvalid), .almostfull_o(almostfull), .empty_o(empty),
    .count_o(count), .overflow_o(overflow), .underflow_o(underflow));

  fifobram_dualmode #(.WIDTH(32), .LOG2_DEPTH(5), .READ_LATENCY(2), .ALMOSTFULL_MARGIN(4)) u_b (
    .clk_i(clk), .reset_i(reset), .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .wfifobram_i(b_wfb), .re_i(b_re), .raddr_i(b_raddr), .rfifobram_i(b_rfb),
    .rdata_o(b_rdata), .rvalid_o(b_rvalid), .almostfull_o(b_almostfull), .empty_o(b_empty),
    .count_o(b_count), .overflow_o(b_overflow), .underflow_o(b_underflow));

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    we = 0; re = 0; waddr = 0; raddr = 0; wdata = 0; wfb = 0; rfb = 0;
    b_we = 0; b_re = 0; b_waddr = 0; b_raddr = 0; b_wdata = 0; b_wfb = 0; b_rfb = 0;
    repeat (2) cyc();
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_afull", almostfull, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    reset = 1'b0;
    cyc();

    // BRAM write/read, latency 1
    we = 1; wfb = 2'b01; waddr = 3; wdata = 32'hDEAD; cyc();
    waddr = 7; wdata = 32'hBEEF; cyc();
    we = 0; re = 1; rfb = 2'b01; raddr = 7; cyc();
    chk("bram_rv7", rvalid, 1);
    chk("bram_rd7", rdata, 32'hBEEF);
    raddr = 3; cyc();
    chk("bram_rv3", rvalid, 1);
    chk("bram_rd3", rdata, 32'hDEAD);
    re = 0; cyc();
    chk("bram_rv_idle", rvalid, 0);
    chk("bram_rd_hold", rdata, 32'hDEAD);
    we = 1; wfb = 2'b01; waddr = 3; wdata = 32'hFACE; re = 1; rfb = 2'b01; raddr = 3; cyc();
    chk("rdw_old", rdata, 32'hDEAD);
    we = 0; cyc();
    chk("rdw_new", rdata, 32'hFACE);
    re = 0; cyc();
    chk("bram_no_fifo", count, 0);

    // Latency 2: back-to-back reads of addr 0..7
    b_we = 1; b_wfb = 2'b01;
    for (int i = 0; i < 8; i++) begin
      b_waddr = 5'(i); b_wdata = 32'h50 + i; cyc();
    end
    b_we = 0; b_rfb = 2'b01;
    for (int k = 0; k < 10; k++) begin
      b_re = (k < 8); b_raddr = 5'(k); cyc();
      chk($sformatf("lat2_rv%0d", k), b_rvalid, (k >= 1 && k <= 8));
      if (k >= 1 && k <= 8) chk($sformatf("lat2_rd%0d", k), b_rdata, 32'h50 + k - 1);
    end
    b_we = 1; b_waddr = 2; b_wdata = 32'hAAAA; b_re = 1; b_raddr = 2; cyc();
    b_we = 0; b_re = 0;
    chk("lat2_rdw_rv_early", b_rvalid, 0);
    cyc();
    chk("lat2_rdw_rv", b_rvalid, 1);
    chk("lat2_rdw_old", b_rdata, 32'h52);
    b_re = 1; cyc(); b_re = 0; cyc();
    chk("lat2_rdw_new", b_rdata, 32'hAAAA);

    // FIFO fill to full, overflow, drain
    we = 1; wfb = 2'b10;
    for (int i = 0; i < 31; i++) begin
      wdata = 32'h100 + i; cyc();
      chk($sformatf("fill_cnt%0d", i), count, i + 1);
      chk($sformatf("fill_af%0d", i), almostfull, (i + 1 >= 27));
    end
    chk("fill_ovf_pre", overflow, 0);
    wdata = 32'hBAD0; cyc();
    chk("full_cnt", count, 31);
    chk("full_ovf", overflow, 1);
    we = 0; re = 1; rfb = 2'b10;
    for (int i = 0; i < 31; i++) begin
      cyc();
      chk($sformatf("drain_rv%0d", i), rvalid, 1);
      chk($sformatf("drain_rd%0d", i), rdata, 32'h100 + i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_cnt", count, 0);
    re = 0; cyc();
    chk("drain_idle_rv", rvalid, 0);
    chk("drain_unf", underflow, 0);

    // Both-mode write
    we = 1; wfb = 2'b11; waddr = 5; wdata = 32'h1234; cyc();
    we = 0;
    chk("both_cnt", count, 1);
    re = 1; rfb = 2'b01; raddr = 5; cyc();
    chk("both_bram", rdata, 32'h1234);
    rfb = 2'b10; cyc();
    chk("both_fifo_rv", rvalid, 1);
    chk("both_fifo", rdata, 32'h1234);
    chk("both_empty", empty, 1);
    rfb = 2'b11; cyc();
    chk("r11_bram", rdata, 32'h1234);
    chk("r11_no_unf", underflow, 0);
    re = 0; cyc();

    // Push+pop on empty FIFO: no fall-through
    we = 1; wfb = 2'b10; wdata = 32'hA5; re = 1; rfb = 2'b10; cyc();
    chk("pp_empty_rv", rvalid, 0);
    chk("pp_empty_unf", underflow, 1);
    chk("pp_empty_cnt", count, 1);
    re = 0;
    for (int j = 0; j < 9; j++) begin
      wdata = 32'h300 + j; cyc();
    end
    chk("pp_cnt10", count, 10);
    wdata = 32'h200; re = 1; cyc();
    chk("pp10_cnt", count, 10);
    chk("pp10_rd", rdata, 32'hA5);
    we = 0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      chk($sformatf("pp_drain%0d", j), rdata, (j < 9) ? 32'h300 + j : 32'h200);
    end
    re = 0;
    chk("pp_drain_empty", empty, 1);

    // Pointer wrap: 100 words streamed through with occupancy 1
    we = 1; wfb = 2'b10; rfb = 2'b10;
    for (int i = 0; i < 100; i++) begin
      wdata = 32'h1000 + i; re = (i > 0); cyc();
      if (i > 0) chk($sformatf("wrap_rd%0d", i), rdata, 32'h1000 + i - 1);
    end
    we = 0; re = 1; cyc();
    chk("wrap_last", rdata, 32'h1000 + 99);
    chk("wrap_empty", empty, 1);
    re = 0;

    // Reset with reads in flight and count=6
    we = 1; wfb = 2'b10;
    for (int i = 0; i < 6; i++) begin
      wdata = 32'h700 + i; cyc();
    end
    we = 0;
    chk("pre_rst_cnt", count, 6);
    b_re = 1; b_rfb = 2'b01; b_raddr = 0; cyc();
    b_raddr = 1; re = 1; rfb = 2'b01; raddr = 3; reset = 1; cyc();
    b_re = 0; re = 0;
    chk("rst_fly_b_rv0", b_rvalid, 0);
    chk("rst_fly_a_rv0", rvalid, 0);
    cyc();
    chk("rst_fly_b_rv1", b_rvalid, 0);
    reset = 0; cyc();
    chk("rst_fly_b_rv2", b_rvalid, 0);
    chk("rst_fly_a_rv", rvalid, 0);
    chk("rst_fly_cnt", count, 0);
    chk("rst_fly_empty", empty, 1);
    chk("rst_fly_ovf", overflow, 0);
    chk("rst_fly_unf", underflow, 0);
    chk("rst_fly_b_rd", b_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
